// File: rtl/warp_pkg.sv
// Shared types for the SIMT divergence/reconvergence controller and its stack.
package warp_pkg;

  localparam int WARP_NUM_LANES = 8;
  localparam int WARP_PC_WIDTH  = 32;

  typedef enum logic {
    TAKEN = 1'b0,
    ELSE  = 1'b1
  } recon_phase_e;

  typedef struct packed {
    logic [WARP_PC_WIDTH-1:0]  reconv_pc;
    logic [WARP_NUM_LANES-1:0] full_mask;
    logic [WARP_NUM_LANES-1:0] else_mask;
    logic [WARP_PC_WIDTH-1:0]  else_pc;
    recon_phase_e              phase;
  } recon_entry_t;

endpackage

// File: rtl/warp_reconv_ctrl_if.sv
// Issue-side bundle between the issuer/warp_mask and warp_reconv_ctrl.
interface warp_reconv_ctrl_if #(
  parameter int NUM_LANES   = warp_pkg::WARP_NUM_LANES,
  parameter int STACK_DEPTH = 4,
  parameter int PC_WIDTH    = warp_pkg::WARP_PC_WIDTH
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [NUM_LANES-1:0] cur_mask;
  logic                 branch_valid;
  logic                 branch_ready;
  logic [NUM_LANES-1:0] branch_taken;
  logic [PC_WIDTH-1:0]  target_pc;
  logic [PC_WIDTH-1:0]  fallthru_pc;
  logic [PC_WIDTH-1:0]  reconv_pc;
  logic                 pc_valid;
  logic [PC_WIDTH-1:0]  pc_in;
  logic                 mask_update;
  logic [NUM_LANES-1:0] mask_in;
  logic                 redirect_valid;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic [DEPTH_W-1:0]   stack_depth;
  logic                 stack_empty;
  logic                 stack_full;

  modport master (
    output cur_mask, branch_valid, branch_taken, target_pc, fallthru_pc,
           reconv_pc, pc_valid, pc_in,
    input  branch_ready, mask_update, mask_in, redirect_valid, redirect_pc,
           stack_depth, stack_empty, stack_full
  );

  modport slave (
    input  cur_mask, branch_valid, branch_taken, target_pc, fallthru_pc,
           reconv_pc, pc_valid, pc_in,
    output branch_ready, mask_update, mask_in, redirect_valid, redirect_pc,
           stack_depth, stack_empty, stack_full
  );
endinterface

// File: rtl/warp_simt_stack.sv
// LIFO of reconvergence entries; the top entry may be rewritten in place.
module warp_simt_stack
  import warp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  recon_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       top_wr,
  input  recon_entry_t               top_wr_data,
  output recon_entry_t               top_entry,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  recon_entry_t       mem [DEPTH];
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   top_idx;
  logic [PTR_W-1:0]   push_idx;

  assign top_idx   = PTR_W'(count - CNT_W'(1));
  assign push_idx  = PTR_W'(count);
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign depth     = count;
  assign top_entry = empty ? '0 : mem[top_idx];

  // Push and pop are guarded here so the depth can neither overflow nor underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[push_idx] <= push_entry;
        count         <= count + CNT_W'(1);
      end else if (pop && !empty) begin
        count <= count - CNT_W'(1);
      end
      if (top_wr && !empty && !push) mem[top_idx] <= top_wr_data;
    end
  end
endmodule

// File: rtl/warp_reconv_ctrl.sv
// SIMT divergence/reconvergence controller: splits a warp on divergent branches
// and drives warp_mask plus fetch redirects, restoring masks at reconvergence.
module warp_reconv_ctrl
  import warp_pkg::*;
#(
  parameter int NUM_LANES   = WARP_NUM_LANES,
  parameter int STACK_DEPTH = 4,
  parameter int PC_WIDTH    = WARP_PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  warp_reconv_ctrl_if.slave bus
);
  recon_entry_t         top_entry;
  recon_entry_t         push_entry;
  recon_entry_t         top_wr_data;
  logic                 push, pop, top_wr;
  logic                 stk_empty, stk_full;
  logic                 reconv_hit, accept;
  logic [NUM_LANES-1:0] taken_m, not_m;
  logic                 mask_update_d, redirect_valid_d;
  logic [NUM_LANES-1:0] mask_in_d;
  logic [PC_WIDTH-1:0]  redirect_pc_d;

  assign taken_m    = bus.branch_taken & bus.cur_mask;
  assign not_m      = ~bus.branch_taken & bus.cur_mask;
  assign reconv_hit = bus.pc_valid && !stk_empty && (bus.pc_in == top_entry.reconv_pc);
  // Reconvergence wins over a simultaneous branch; the issuer holds the branch.
  assign bus.branch_ready = !stk_full && !reconv_hit;
  assign accept           = bus.branch_valid && bus.branch_ready;
  assign bus.stack_empty  = stk_empty;
  assign bus.stack_full   = stk_full;

  always_comb begin
    push             = 1'b0;
    pop              = 1'b0;
    top_wr           = 1'b0;
    top_wr_data      = top_entry;
    push_entry       = '{reconv_pc: bus.reconv_pc, full_mask: bus.cur_mask,
                         else_mask: not_m, else_pc: bus.fallthru_pc, phase: TAKEN};
    mask_update_d    = 1'b0;
    mask_in_d        = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    if (reconv_hit) begin
      mask_update_d = 1'b1;
      if (top_entry.phase == TAKEN) begin
        top_wr            = 1'b1;
        top_wr_data.phase = ELSE;
        mask_in_d         = top_entry.else_mask;
        redirect_valid_d  = 1'b1;
        redirect_pc_d     = top_entry.else_pc;
      end else begin
        pop       = 1'b1;
        mask_in_d = top_entry.full_mask;
      end
    end else if (accept && (taken_m != '0)) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = bus.target_pc;
      if (not_m != '0) begin
        push          = 1'b1;
        mask_update_d = 1'b1;
        mask_in_d     = taken_m;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mask_update    <= 1'b0;
      bus.mask_in        <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
    end else begin
      bus.mask_update    <= mask_update_d;
      bus.mask_in        <= mask_in_d;
      bus.redirect_valid <= redirect_valid_d;
      bus.redirect_pc    <= redirect_pc_d;
    end
  end

  warp_simt_stack #(.DEPTH(STACK_DEPTH)) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .top_wr      (top_wr),
    .top_wr_data (top_wr_data),
    .top_entry   (top_entry),
    .depth       (bus.stack_depth),
    .empty       (stk_empty),
    .full        (stk_full)
  );
endmodule

// File: tb/tb_warp_reconv_ctrl.sv
// Table-driven bench for warp_reconv_ctrl with a scoreboard queue of expected
// registered outputs, plus a hand-written mid-divergence reset sequence.
module tb_warp_reconv_ctrl;
  logic clk;
  logic rst_n;

  warp_reconv_ctrl_if #(.NUM_LANES(8), .STACK_DEPTH(4), .PC_WIDTH(32)) bus ();

  warp_reconv_ctrl #(.NUM_LANES(8), .STACK_DEPTH(4), .PC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        bv;
    logic [7:0]  cur;
    logic [7:0]  tk;
    logic [31:0] tgt;
    logic [31:0] ft;
    logic [31:0] rc;
    logic        pv;
    logic [31:0] pcin;
    logic        ready;
    logic        mu;
    logic [7:0]  mask;
    logic        rv;
    logic [31:0] rpc;
    int          depth;
  } vec_t;

  typedef struct {
    logic        mu;
    logic [7:0]  mask;
    logic        rv;
    logic [31:0] rpc;
    int          depth;
  } exp_t;

  vec_t vecs[29];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic bv, logic [7:0] cur, logic [7:0] tk, logic [31:0] tgt,
                              logic [31:0] ft, logic [31:0] rc, logic pv, logic [31:0] pcin,
                              logic ready, logic mu, logic [7:0] mask, logic rv,
                              logic [31:0] rpc, int depth);
    vec_t v;
    v = '{bv, cur, tk, tgt, ft, rc, pv, pcin, ready, mu, mask, rv, rpc, depth};
    return v;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_underflow actual=0 required=1");
      return;
    end
    e = sb.pop_front();
    checkVal("mask_update", 32'(bus.mask_update), 32'(e.mu));
    if (e.mu) checkVal("mask_in", 32'(bus.mask_in), 32'(e.mask));
    checkVal("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
    if (e.rv) checkVal("redirect_pc", bus.redirect_pc, e.rpc);
    checkVal("stack_depth", 32'(bus.stack_depth), 32'(e.depth));
    checkVal("stack_empty", 32'(bus.stack_empty), 32'(e.depth == 0));
    checkVal("stack_full", 32'(bus.stack_full), 32'(e.depth == 4));
  endtask

  // Drives one vector just after a rising edge, checks the combinational ready,
  // then compares the registered response one edge later.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bus.branch_valid = v.bv;
    bus.cur_mask     = v.cur;
    bus.branch_taken = v.tk;
    bus.target_pc    = v.tgt;
    bus.fallthru_pc  = v.ft;
    bus.reconv_pc    = v.rc;
    bus.pc_valid     = v.pv;
    bus.pc_in        = v.pcin;
    #1;
    checkVal("branch_ready", 32'(bus.branch_ready), 32'(v.ready));
    e = '{v.mu, v.mask, v.rv, v.rpc, v.depth};
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic driveIdle();
    bus.branch_valid = 1'b0;
    bus.cur_mask     = 8'hFF;
    bus.branch_taken = 8'h00;
    bus.target_pc    = '0;
    bus.fallthru_pc  = '0;
    bus.reconv_pc    = '0;
    bus.pc_valid     = 1'b0;
    bus.pc_in        = '0;
  endtask

  task automatic checkResetState(string tag);
    checkVal({tag, "_mask_update"}, 32'(bus.mask_update), 32'(0));
    checkVal({tag, "_mask_in"}, 32'(bus.mask_in), 32'(0));
    checkVal({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'(0));
    checkVal({tag, "_redirect_pc"}, bus.redirect_pc, 32'(0));
    checkVal({tag, "_stack_depth"}, 32'(bus.stack_depth), 32'(0));
    checkVal({tag, "_stack_empty"}, 32'(bus.stack_empty), 32'(1));
    checkVal({tag, "_stack_full"}, 32'(bus.stack_full), 32'(0));
    checkVal({tag, "_branch_ready"}, 32'(bus.branch_ready), 32'(1));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Uniform and non-participating branches
    vecs[0]  = mk(1, 8'hFF, 8'hFF, 32'h40, 32'h20, 32'h80, 0, 32'h0,  1, 0, 8'h00, 1, 32'h40, 0);
    vecs[1]  = mk(1, 8'hFF, 8'h00, 32'h40, 32'h20, 32'h80, 0, 32'h0,  1, 0, 8'h00, 0, 32'h0,  0);
    vecs[2]  = mk(1, 8'h00, 8'hFF, 32'h40, 32'h20, 32'h80, 0, 32'h0,  1, 0, 8'h00, 0, 32'h0,  0);
    // Single divergence and reconvergence
    vecs[3]  = mk(1, 8'hFF, 8'h0F, 32'h40, 32'h20, 32'h80, 0, 32'h0,  1, 1, 8'h0F, 1, 32'h40, 1);
    vecs[4]  = mk(0, 8'h0F, 8'h00, 32'h0,  32'h0,  32'h0,  1, 32'h80, 0, 1, 8'hF0, 1, 32'h20, 1);
    vecs[5]  = mk(0, 8'hF0, 8'h00, 32'h0,  32'h0,  32'h0,  1, 32'h84, 1, 0, 8'h00, 0, 32'h0,  1);
    vecs[6]  = mk(0, 8'hF0, 8'h00, 32'h0,  32'h0,  32'h0,  1, 32'h80, 0, 1, 8'hFF, 0, 32'h0,  0);
    vecs[7]  = mk(0, 8'hFF, 8'h00, 32'h0,  32'h0,  32'h0,  1, 32'h80, 1, 0, 8'h00, 0, 32'h0,  0);
    // Four nested divergences, held fifth branch, pop then accept
    vecs[8]  = mk(1, 8'hFF, 8'h7F, 32'h100, 32'h200, 32'h300, 0, 32'h0, 1, 1, 8'h7F, 1, 32'h100, 1);
    vecs[9]  = mk(1, 8'h7F, 8'h3F, 32'h110, 32'h210, 32'h310, 0, 32'h0, 1, 1, 8'h3F, 1, 32'h110, 2);
    vecs[10] = mk(1, 8'h3F, 8'h1F, 32'h120, 32'h220, 32'h320, 0, 32'h0, 1, 1, 8'h1F, 1, 32'h120, 3);
    vecs[11] = mk(1, 8'h1F, 8'h0F, 32'h130, 32'h230, 32'h330, 0, 32'h0, 1, 1, 8'h0F, 1, 32'h130, 4);
    vecs[12] = mk(1, 8'h0F, 8'h07, 32'h140, 32'h240, 32'h340, 0, 32'h0,   0, 0, 8'h00, 0, 32'h0,   4);
    vecs[13] = mk(1, 8'h0F, 8'h07, 32'h140, 32'h240, 32'h340, 1, 32'h330, 0, 1, 8'h10, 1, 32'h230, 4);
    vecs[14] = mk(1, 8'h0F, 8'h07, 32'h140, 32'h240, 32'h340, 1, 32'h330, 0, 1, 8'h1F, 0, 32'h0,   3);
    vecs[15] = mk(1, 8'h0F, 8'h07, 32'h140, 32'h240, 32'h340, 0, 32'h0,   1, 1, 8'h07, 1, 32'h140, 4);
    // LIFO unwind
    vecs[16] = mk(0, 8'h07, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h340, 0, 1, 8'h08, 1, 32'h240, 4);
    vecs[17] = mk(0, 8'h08, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h340, 0, 1, 8'h0F, 0, 32'h0,   3);
    vecs[18] = mk(0, 8'h0F, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h320, 0, 1, 8'h20, 1, 32'h220, 3);
    vecs[19] = mk(0, 8'h20, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h320, 0, 1, 8'h3F, 0, 32'h0,   2);
    vecs[20] = mk(0, 8'h3F, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h310, 0, 1, 8'h40, 1, 32'h210, 2);
    vecs[21] = mk(0, 8'h40, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h310, 0, 1, 8'h7F, 0, 32'h0,   1);
    vecs[22] = mk(0, 8'h7F, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h300, 0, 1, 8'h80, 1, 32'h200, 1);
    vecs[23] = mk(0, 8'h80, 8'h00, 32'h0, 32'h0, 32'h0, 1, 32'h300, 0, 1, 8'hFF, 0, 32'h0,   0);
    // Reconvergence colliding with a branch
    vecs[24] = mk(1, 8'hFF, 8'hF0, 32'h500, 32'h600, 32'h700, 0, 32'h0,   1, 1, 8'hF0, 1, 32'h500, 1);
    vecs[25] = mk(1, 8'hF0, 8'hC0, 32'h510, 32'h610, 32'h720, 1, 32'h700, 0, 1, 8'h0F, 1, 32'h600, 1);
    vecs[26] = mk(1, 8'hF0, 8'hC0, 32'h510, 32'h610, 32'h720, 0, 32'h0,   1, 1, 8'hC0, 1, 32'h510, 2);
    // After a mid-divergence reset
    vecs[27] = mk(0, 8'hFF, 8'h00, 32'h0,   32'h0,   32'h0,   1, 32'h700, 1, 0, 8'h00, 0, 32'h0,   0);
    vecs[28] = mk(1, 8'hFF, 8'h33, 32'h800, 32'h900, 32'hA00, 0, 32'h0,   1, 1, 8'h33, 1, 32'h800, 1);

    rst_n = 1'b0;
    driveIdle();
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 27; i++) applyStimulus(vecs[i]);

    checkVal("pre_reset_mask_update", 32'(bus.mask_update), 32'(1));
    checkVal("pre_reset_depth", 32'(bus.stack_depth), 32'(2));
    #2;
    driveIdle();
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 27; i < 29; i++) applyStimulus(vecs[i]);

    checkVal("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
